// File: rtl/fma_sched_pkg.sv
// Shared definitions for the FMA scheduler and its round-robin arbiter.
//
// Contents:
//   - f64 field widths and the flag-vector layout {overflow, underflow, out_valid}
//   - scheduler state encoding (IDLE=0, WAIT=1, RESPOND=2) and its enum
//   - clogb2: bits needed to hold values 0..n-1 (never less than 1)
package fma_sched_pkg;

    localparam int F64_EXP_BITS = 11;
    localparam int F64_MAN_BITS = 52;
    localparam int F64_WIDTH    = 1 + F64_EXP_BITS + F64_MAN_BITS;

    localparam int FLAG_BITS = 3;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_VLD  = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        WAIT    = ST_WAIT,
        RESPOND = ST_RESPOND
    } sched_state_e;

    // A width of at least one bit keeps single-value counters and pointers legal.
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker, shared by the schedulers that front a
// single resource.
//
// Ports:
//   req    in  N   request vector
//   ptr    in  PW  index of the last winner; the search starts at ptr+1
//   enable in  1   when low, no grant is issued
//   grant  out N   one-hot (or zero) grant
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant
);

    // Walk the candidates in priority order (ptr+1, ptr+2, ... with wrap).
    // The first asserted request wins; the found flag keeps the grant one-hot.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (enable && !found && req[i] && (i == ((int'(ptr) + k) % N))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fma_scheduler.sv
// Round-robin scheduler sharing one external f64 fused multiply-add datapath
// between NUM_REQ requesters. One job at a time: the operands are registered
// onto the datapath, held for LATENCY cycles (multicycle combinational path),
// then the result and flags are captured and returned to the owner with
// valid/ready backpressure.
//
// Ports:
//   ACLK, ARESET              clock, synchronous active-high reset
//   req_valid/req_ready       per-requester job handshake (ready is one-hot)
//   req_a/req_b/req_c         packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready       per-requester result handshake (valid is one-hot)
//   rsp_data, rsp_flags       captured result and {ovf, unf, valid}
//   fma_a/fma_b/fma_c         registered operands driven to the datapath
//   fma_result, fma_flags     datapath outputs
//   busy                      high whenever a job is in flight
//   op_count                  completed-job counter (wraps)
module fma_scheduler
    import fma_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int EXPONENT_BITS = 11,
    parameter int MANTISSA_BITS = 52,
    parameter int LATENCY       = 2,
    localparam int W            = 1 + EXPONENT_BITS + MANTISSA_BITS
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [NUM_REQ*W-1:0] req_c,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [2:0]           rsp_flags,
    output logic [W-1:0]         fma_a,
    output logic [W-1:0]         fma_b,
    output logic [W-1:0]         fma_c,
    input  logic [W-1:0]         fma_result,
    input  logic [2:0]           fma_flags,
    output logic                 busy,
    output logic [31:0]          op_count
);

    localparam int PW = clogb2(NUM_REQ);
    localparam int CW = clogb2(LATENCY + 1);

    sched_state_e   state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   fma_a_q, fma_a_d;
    logic [W-1:0]   fma_b_q, fma_b_d;
    logic [W-1:0]   fma_c_q, fma_c_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic [2:0]     rsp_flags_q, rsp_flags_d;
    logic [31:0]    op_count_q, op_count_d;

    logic [NUM_REQ-1:0] grant;
    logic               arb_en;

    // Grants are only offered while idle, and never during reset so that
    // req_ready reads zero for the whole reset cycle.
    assign arb_en = (state_q == IDLE) && !ARESET;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (arb_en),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign busy      = (state_q != IDLE);
    assign fma_a     = fma_a_q;
    assign fma_b     = fma_b_q;
    assign fma_c     = fma_c_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign op_count  = op_count_q;

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESPOND) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    // Next-state logic. A granted request is always a handshake because the
    // grant is issued only to an asserted req_valid. The operand registers are
    // written only on accept, so the datapath inputs stay still for the whole
    // job and after it.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        fma_a_d     = fma_a_q;
        fma_b_d     = fma_b_q;
        fma_c_d     = fma_c_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant[i]) begin
                        fma_a_d = req_a[i*W +: W];
                        fma_b_d = req_b[i*W +: W];
                        fma_c_d = req_c[i*W +: W];
                        owner_d = PW'(i);
                        ptr_d   = PW'(i);
                        cnt_d   = CW'(LATENCY);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // cnt==1 marks the last cycle the operands must be held, so
                // the datapath output has settled by the end of it.
                if (cnt_q == CW'(1)) begin
                    rsp_data_d  = fma_result;
                    rsp_flags_d = fma_flags;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready[owner_q]) begin
                    op_count_d = op_count_q + 32'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any job in flight and restores requester 0
    // as first in line.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(NUM_REQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            fma_a_q     <= '0;
            fma_b_q     <= '0;
            fma_c_q     <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            fma_a_q     <= fma_a_d;
            fma_b_q     <= fma_b_d;
            fma_c_q     <= fma_c_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            op_count_q  <= op_count_d;
        end
    end

endmodule

// File: tb/tb_fma_scheduler.sv
// Self-checking bench for fma_scheduler. An arithmetic stand-in for the
// shared FMA datapath sits on the fma_* ports; expected grants, results,
// latencies and job counts come from a round-robin reference model kept here.
module tb_fma_scheduler;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int LAT = 2;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b, req_c;
    logic [W-1:0]   rsp_data, fma_a, fma_b, fma_c, fma_result;
    logic [2:0]     rsp_flags, fma_flags;
    logic           busy;
    logic [31:0]    op_count;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] model_ops;

    fma_scheduler #(
        .NUM_REQ       (N),
        .EXPONENT_BITS (11),
        .MANTISSA_BITS (52),
        .LATENCY       (LAT)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .fma_a      (fma_a),
        .fma_b      (fma_b),
        .fma_c      (fma_c),
        .fma_result (fma_result),
        .fma_flags  (fma_flags),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 ACLK = ~ACLK;

    // Reference arithmetic: a*b+c in double precision.
    function automatic logic [63:0] fma_ref(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        real r;
        r = $bitstoreal(a) * $bitstoreal(b) + $bitstoreal(c);
        return $realtobits(r);
    endfunction

    // Overflow when the result exponent saturates; no underflow for these operands.
    function automatic logic [2:0] flags_ref(input logic [63:0] r);
        return {(r[62:52] == 11'h7FF), 1'b0, 1'b1};
    endfunction

    function automatic logic [63:0] rnd_op();
        return $realtobits(real'(int'($urandom_range(0, 200)) - 100) / 4.0);
    endfunction

    assign fma_result = fma_ref(fma_a, fma_b, fma_c);
    assign fma_flags  = flags_ref(fma_result);

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic applyStimulus(input int r, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_c[r*W +: W] = c;
        req_valid[r]    = 1'b1;
    endtask

    task automatic pulse_reset();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        model_ops = 0;
    endtask

    // Drives one job through: waits (bounded) for a grant, lets it be accepted,
    // waits (bounded) for the response and lets it be accepted with whatever
    // rsp_ready the caller has set. Reports what it observed; no judging here.
    task automatic runJob(input bit drop, output int g, output logic [63:0] d, output logic [2:0] f,
                          output logic [N-1:0] rv, output int lat, output bit timeout, output bit multihot);
        g = -1; d = '0; f = '0; rv = '0; lat = 0; timeout = 1'b0; multihot = 1'b0;
        for (int k = 0; k < 20 && g < 0; k++) begin
            #2;
            if ($countones(req_ready) > 1) multihot = 1'b1;
            for (int i = 0; i < N; i++) if (req_ready[i] && g < 0) g = i;
            tick();
        end
        if (g < 0) begin
            timeout = 1'b1;
            return;
        end
        if (drop) req_valid[g] = 1'b0;
        for (lat = 1; lat < 20; lat++) begin
            #2;
            if (rsp_valid != 0) break;
            tick();
        end
        if (rsp_valid == 0) begin
            timeout = 1'b1;
            return;
        end
        rv = rsp_valid; d = rsp_data; f = rsp_flags;
        tick();
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) applyStimulus(i, rnd_op(), rnd_op(), rnd_op());
        tick();
        tick();
        #2;
        checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_req_ready: got %b, expected 0000", req_ready); else passes++;
        checks++; if (rsp_valid !== 4'b0000) $display("[TB] FAIL reset_rsp_valid: got %b, expected 0000", rsp_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy); else passes++;
        checks++; if (op_count !== 32'd0) $display("[TB] FAIL reset_op_count: got %0d, expected 0", op_count); else passes++;
        checks++; if ({fma_a, fma_b, fma_c} !== '0) $display("[TB] FAIL reset_fma_ops: got %h %h %h, expected zeros", fma_a, fma_b, fma_c); else passes++;
        checks++; if (rsp_data !== 64'd0) $display("[TB] FAIL reset_rsp_data: got %h, expected 0", rsp_data); else passes++;
        checks++; if (rsp_flags !== 3'b000) $display("[TB] FAIL reset_rsp_flags: got %b, expected 000", rsp_flags); else passes++;
        ARESET = 1'b0;
        req_valid = '0;
        model_ops = 0;
        tick();
    endtask

    task automatic test_single_job();
        rsp_ready = '0;
        applyStimulus(1, 64'h4000000000000000, 64'h4008000000000000, 64'h3FF0000000000000);
        #2;
        checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL single_grant: got %b, expected 0010", req_ready); else passes++;
        tick();
        req_valid[1] = 1'b0;
        #2;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL single_busy_rise: got %b, expected 1", busy); else passes++;
        checks++; if ({fma_a, fma_b, fma_c} !== {64'h4000000000000000, 64'h4008000000000000, 64'h3FF0000000000000})
            $display("[TB] FAIL single_fma_ops: got %h %h %h, expected requester 1 operands", fma_a, fma_b, fma_c); else passes++;
        checks++; if (rsp_valid !== 4'b0000) $display("[TB] FAIL single_rsp_early_t1: got %b, expected 0000", rsp_valid); else passes++;
        tick();
        #2;
        checks++; if (rsp_valid !== 4'b0000) $display("[TB] FAIL single_rsp_early_t2: got %b, expected 0000", rsp_valid); else passes++;
        tick();
        #2;
        checks++; if (rsp_valid !== 4'b0010) $display("[TB] FAIL single_rsp_valid_t3: got %b, expected 0010", rsp_valid); else passes++;
        checks++; if (rsp_data !== 64'h401C000000000000) $display("[TB] FAIL single_rsp_data: got %h, expected 401c000000000000", rsp_data); else passes++;
        checks++; if (rsp_flags !== 3'b001) $display("[TB] FAIL single_rsp_flags: got %b, expected 001", rsp_flags); else passes++;
        rsp_ready = 4'b0010;
        tick();
        model_ops++;
        #2;
        checks++; if (op_count !== model_ops) $display("[TB] FAIL single_op_count: got %0d, expected %0d", op_count, model_ops); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_fall: got %b, expected 0", busy); else passes++;
        checks++; if (rsp_valid !== 4'b0000) $display("[TB] FAIL single_rsp_drop: got %b, expected 0000", rsp_valid); else passes++;
        rsp_ready = '1;
    endtask

    task automatic test_simultaneous();
        logic [63:0] a0, b0, c0, a2, b2, c2, d;
        logic [2:0] f;
        logic [N-1:0] rv;
        int g, lat;
        bit to, mh;
        pulse_reset();
        rsp_ready = '1;
        a0 = rnd_op(); b0 = rnd_op(); c0 = rnd_op();
        a2 = rnd_op(); b2 = rnd_op(); c2 = rnd_op();
        applyStimulus(0, a0, b0, c0);
        applyStimulus(2, a2, b2, c2);
        runJob(1'b1, g, d, f, rv, lat, to, mh);
        model_ops++;
        checks++; if (to || g !== 0) $display("[TB] FAIL simul_first_grant: got %0d (timeout %0d), expected 0", g, to); else passes++;
        checks++; if (mh) $display("[TB] FAIL simul_onehot_1: got multi-hot req_ready, expected one-hot"); else passes++;
        checks++; if (d !== fma_ref(a0, b0, c0)) $display("[TB] FAIL simul_data_0: got %h, expected %h", d, fma_ref(a0, b0, c0)); else passes++;
        runJob(1'b1, g, d, f, rv, lat, to, mh);
        model_ops++;
        checks++; if (to || g !== 2) $display("[TB] FAIL simul_second_grant: got %0d (timeout %0d), expected 2", g, to); else passes++;
        checks++; if (mh) $display("[TB] FAIL simul_onehot_2: got multi-hot req_ready, expected one-hot"); else passes++;
        checks++; if (d !== fma_ref(a2, b2, c2)) $display("[TB] FAIL simul_data_2: got %h, expected %h", d, fma_ref(a2, b2, c2)); else passes++;
        #2;
        checks++; if (op_count !== model_ops) $display("[TB] FAIL simul_op_count: got %0d, expected %0d", op_count, model_ops); else passes++;
    endtask

    task automatic test_round_robin();
        logic [63:0] oa [N], ob [N], oc [N];
        logic [63:0] d;
        logic [2:0] f;
        logic [N-1:0] rv;
        int g, lat;
        bit to, mh;
        pulse_reset();
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            oa[i] = rnd_op(); ob[i] = rnd_op(); oc[i] = rnd_op();
            applyStimulus(i, oa[i], ob[i], oc[i]);
        end
        for (int j = 0; j < 8; j++) begin
            runJob(1'b0, g, d, f, rv, lat, to, mh);
            model_ops++;
            checks++; if (to || g !== (j % N)) $display("[TB] FAIL rr_grant_%0d: got %0d (timeout %0d), expected %0d", j, g, to, j % N); else passes++;
            checks++; if (d !== fma_ref(oa[j % N], ob[j % N], oc[j % N])) $display("[TB] FAIL rr_data_%0d: got %h, expected %h", j, d, fma_ref(oa[j % N], ob[j % N], oc[j % N])); else passes++;
        end
        req_valid = '0;
        #2;
        checks++; if (op_count !== model_ops) $display("[TB] FAIL rr_op_count: got %0d, expected %0d", op_count, model_ops); else passes++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, c, dref, a0, b0, c0, d;
        logic [2:0] f;
        logic [N-1:0] rv;
        int g, lat;
        bit to, mh;
        a = rnd_op(); b = rnd_op(); c = rnd_op();
        dref = fma_ref(a, b, c);
        rsp_ready = 4'b1011;
        applyStimulus(2, a, b, c);
        #2;
        checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL bp_grant: got %b, expected 0100", req_ready); else passes++;
        tick();
        req_valid[2] = 1'b0;
        tick();
        tick();
        a0 = rnd_op(); b0 = rnd_op(); c0 = rnd_op();
        applyStimulus(0, a0, b0, c0);
        for (int k = 0; k < 5; k++) begin
            #2;
            checks++;
            if ({rsp_valid, rsp_data, busy, req_ready} !== {4'b0100, dref, 1'b1, 4'b0000})
                $display("[TB] FAIL bp_hold_%0d: got valid %b data %h busy %b ready %b, expected 0100 %h 1 0000",
                         k, rsp_valid, rsp_data, busy, req_ready, dref);
            else passes++;
            tick();
        end
        rsp_ready = '1;
        tick();
        model_ops++;
        #2;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL bp_busy_after: got %b, expected 0", busy); else passes++;
        checks++; if (op_count !== model_ops) $display("[TB] FAIL bp_op_count: got %0d, expected %0d", op_count, model_ops); else passes++;
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL bp_next_grant: got %b, expected 0001", req_ready); else passes++;
        runJob(1'b1, g, d, f, rv, lat, to, mh);
        model_ops++;
        checks++; if (to || g !== 0 || d !== fma_ref(a0, b0, c0)) $display("[TB] FAIL bp_next_job: got req %0d data %h (timeout %0d), expected req 0 data %h", g, d, to, fma_ref(a0, b0, c0)); else passes++;
    endtask

    task automatic test_reset_mid_job();
        logic [63:0] a0, b0, c0, d;
        logic [2:0] f;
        logic [N-1:0] rv;
        int g, lat;
        bit to, mh;
        rsp_ready = '1;
        applyStimulus(3, rnd_op(), rnd_op(), rnd_op());
        #2;
        checks++; if (req_ready !== 4'b1000) $display("[TB] FAIL midrst_grant: got %b, expected 1000", req_ready); else passes++;
        tick();
        req_valid[3] = 1'b0;
        pulse_reset();
        #2;
        checks++; if ({busy, rsp_valid, op_count, rsp_data, rsp_flags} !== '0)
            $display("[TB] FAIL midrst_outputs: got busy %b valid %b count %0d data %h flags %b, expected zeros", busy, rsp_valid, op_count, rsp_data, rsp_flags); else passes++;
        checks++; if ({fma_a, fma_b, fma_c} !== '0) $display("[TB] FAIL midrst_fma_ops: got %h %h %h, expected zeros", fma_a, fma_b, fma_c); else passes++;
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            checks++; if (rsp_valid !== 4'b0000) $display("[TB] FAIL midrst_no_rsp_%0d: got %b, expected 0000", k, rsp_valid); else passes++;
        end
        tick();
        a0 = rnd_op(); b0 = rnd_op(); c0 = rnd_op();
        applyStimulus(0, a0, b0, c0);
        runJob(1'b1, g, d, f, rv, lat, to, mh);
        model_ops++;
        checks++; if (to || g !== 0 || d !== fma_ref(a0, b0, c0)) $display("[TB] FAIL midrst_next_job: got req %0d data %h (timeout %0d), expected req 0 data %h", g, d, to, fma_ref(a0, b0, c0)); else passes++;
        #2;
        checks++; if (op_count !== model_ops) $display("[TB] FAIL midrst_op_count: got %0d, expected %0d", op_count, model_ops); else passes++;
    endtask

    task automatic test_overflow();
        logic [63:0] d;
        logic [2:0] f;
        logic [N-1:0] rv;
        int g, lat;
        bit to, mh;
        applyStimulus(1, 64'h7FE0000000000000, 64'h7FE0000000000000, 64'h0);
        runJob(1'b1, g, d, f, rv, lat, to, mh);
        model_ops++;
        checks++; if (to || f[2] !== 1'b1) $display("[TB] FAIL ovf_flag: got flags %b (timeout %0d), expected bit2 set", f, to); else passes++;
        checks++; if (d !== 64'h7FF0000000000000) $display("[TB] FAIL ovf_data: got %h, expected 7ff0000000000000", d); else passes++;
    endtask

    task automatic test_random();
        logic [63:0] oa [N], ob [N], oc [N];
        logic [63:0] d;
        logic [2:0] f;
        logic [N-1:0] rv;
        int g, lat, mptr, expg, r;
        bit to, mh;
        pulse_reset();
        rsp_ready = '1;
        req_valid = '0;
        mptr = N - 1;
        for (int j = 0; j < 24; j++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    oa[i] = rnd_op(); ob[i] = rnd_op(); oc[i] = rnd_op();
                    applyStimulus(i, oa[i], ob[i], oc[i]);
                end
            end
            if (req_valid == '0) begin
                r = int'($urandom_range(0, N - 1));
                oa[r] = rnd_op(); ob[r] = rnd_op(); oc[r] = rnd_op();
                applyStimulus(r, oa[r], ob[r], oc[r]);
            end
            expg = -1;
            for (int k = 1; k <= N; k++) begin
                if (expg < 0 && req_valid[(mptr + k) % N]) expg = (mptr + k) % N;
            end
            runJob(1'b1, g, d, f, rv, lat, to, mh);
            checks++; if (to || g !== expg) $display("[TB] FAIL rand_grant_%0d: got %0d (timeout %0d), expected %0d", j, g, to, expg); else passes++;
            checks++; if (d !== fma_ref(oa[expg], ob[expg], oc[expg]) || f !== flags_ref(fma_ref(oa[expg], ob[expg], oc[expg])))
                $display("[TB] FAIL rand_result_%0d: got %h/%b, expected %h", j, d, f, fma_ref(oa[expg], ob[expg], oc[expg])); else passes++;
            checks++; if (rv !== (4'b0001 << expg) || lat !== LAT + 1) $display("[TB] FAIL rand_rsp_%0d: got valid %b latency %0d, expected %b latency %0d", j, rv, lat, 4'b0001 << expg, LAT + 1); else passes++;
            mptr = expg;
            model_ops++;
        end
        #2;
        checks++; if (op_count !== model_ops) $display("[TB] FAIL rand_op_count: got %0d, expected %0d", op_count, model_ops); else passes++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ARESET    = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        model_ops = 0;
        test_reset();
        test_single_job();
        test_simultaneous();
        test_round_robin();
        test_backpressure();
        test_reset_mid_job();
        test_overflow();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
